mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous RAM among three requesters: device 1 is the instruction pipeline fetch port; devices 2 and 3 are general-purpose.
- Replaces direct device-to-memory wiring. Serialises single and burst accesses, generates burst addresses, and returns a one-cycle do_ack per beat.
- Sits between the device-side mem_en/burst_en/addr/di/we/do_ack bundle and the RAM.

Parameters:
- ADDR_WIDTH, 8, width of all address buses.
- DATA_WIDTH, 8, width of all data buses.
- MAX_BURST, 4, maximum beats per grant; legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- devices_mem_en  in  3  per-device request; bit 0 = device 1.
- devices_burst_en  in  3  per-device burst request; qualified by the matching mem_en bit.
- devices_mem_we  in  3  per-device write enable; 1 = write.
- device_1_mem_addr / device_2_mem_addr / device_3_mem_addr  in  ADDR_WIDTH each  burst base or single address.
- device_1_mem_di / device_2_mem_di / device_3_mem_di  in  DATA_WIDTH each  write data.
- devices_grant  out  3  one-hot current owner; all zero when idle.
- devices_do_ack  out  3  one-cycle beat-complete pulse to the owner.
- mem_do  out  DATA_WIDTH  read data; valid only while an ack bit is high.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_di  out  DATA_WIDTH  RAM write data.
- ram_do  in  DATA_WIDTH  RAM read data; valid one cycle after ram_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=0, do_ack=0, ram_en=0, ram_we=0, ram_addr=0, beat=0, mem_do=0.
  - last_owner=device 3, so device 1 has first priority after reset.
  - Reset asserted mid-burst aborts immediately; no ack is issued for the in-flight beat.
- States are IDLE, ACCESS, RESP.
- IDLE:
  - If any devices_mem_en bit is set, select the first requesting device, searching cyclically starting after last_owner.
  - Latch owner, base=owner addr, we=owner we bit, beat=0. Set grant one-hot and go to ACCESS.
  - grant becomes visible the cycle after the request is sampled.
- ACCESS (one cycle):
  - ram_en=1; ram_we=latched we; ram_addr=base+beat, modulo 2^ADDR_WIDTH (wraps 0xFF->0x00).
  - ram_di passes combinationally from the owner's di; the device holds di until its ack.
  - Next state is RESP.
- RESP (one cycle):
  - ram_en=0; devices_do_ack[owner]=1; mem_do=ram_do on reads, 0 on writes.
  - Continue the burst if the owner's mem_en=1, the owner's burst_en=1 and beat<MAX_BURST-1: beat+=1, go to ACCESS. This re-samples the owner's we bit.
  - Otherwise: last_owner=owner, grant=0, go to IDLE.
- Timing:
  - Single access: request sampled in cycle N, ram_en in N+1, ack in N+2.
  - Beat throughput is one per 2 cycles.
  - A minimum one IDLE cycle separates grants.
- Commitment: once granted, a beat always completes even if mem_en drops during ACCESS. Dropping mem_en or burst_en only ends the burst at the next RESP decision.
- Fairness: the MAX_BURST cap plus round-robin rotation bounds any device's wait to 2×(2×MAX_BURST+1) cycles.
- Non-owner devices never see an ack, and their inputs are ignored.
- Invariants: grant is one-hot or zero; ack is a subset of grant; ram_en is high only in ACCESS.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - device index constants DEV1=0, DEV2=1, DEV3=2;
  - default widths.
- One natural sub-module: rr_select3 (combinational). Inputs are 3-bit req and a 2-bit last_owner; outputs are a one-hot pick and a valid flag.
- Remaining logic (FSM, beat counter, address adder, muxes) lives in mem_arbiter.

Test Plan:
- Single read: RAM[0x10]=0xA5; device 1 raises mem_en with addr 0x10, we=0 in cycle N -> ram_en at N+1 with addr 0x10; ack[0] at N+2 with mem_do=0xA5; grant clears at N+3.
- Write then read: device 2 writes 0x3C to 0x20, then reads 0x20 -> ack[1] on each access; read returns 0x3C.
- Burst wrap: device 3 reads burst from base 0xFE with burst_en held -> ram_addr sequence 0xFE, 0xFF, 0x00, 0x01; exactly 4 acks; fifth beat refused (MAX_BURST=4).
- Round-robin: all three devices request continuously, single accesses -> grant order dev1, dev2, dev3, dev1; no device is granted twice in a row.
- Early burst end: device 1 drops burst_en after its second ack -> exactly 2 beats, then arbiter returns to IDLE and next grant goes to a pending device 2.
- Async reset mid-burst: assert reset between clock edges during ACCESS -> grant, ram_en and ack go to 0 immediately; after release, device 1 wins first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the three-device memory arbiter.
// Holds the FSM encoding, device indices and default bus widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int NUM_DEV        = 3;

  localparam int DEV1 = 0;
  localparam int DEV2 = 1;
  localparam int DEV3 = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [1:0] dev_after(input logic [1:0] dev, input int step);
    return 2'((int'(dev) + step) % NUM_DEV);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_DEV-1:0] oh);
    logic [1:0] idx;
    idx = 2'(DEV1);
    if (oh[DEV2]) idx = 2'(DEV2);
    if (oh[DEV3]) idx = 2'(DEV3);
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select3.sv
// Combinational round-robin pick among three requesters, zero latency.
// Search starts at the device after last_owner; no backpressure, pure function.
module rr_select3
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_DEV-1:0] req_i,
  input  logic [1:0]         last_owner_i,
  output logic [NUM_DEV-1:0] pick_o,
  output logic               valid_o
);

  logic [1:0] cand;

  // Walk the order backwards so the first requester after last_owner overwrites the rest.
  always_comb begin
    pick_o = '0;
    cand   = 2'd0;
    for (int step = NUM_DEV; step >= 1; step--) begin
      cand = dev_after(last_owner_i, step);
      if (req_i[cand]) pick_o = 3'b001 << cand;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port sync RAM among three devices.
// Request->ram_en 1 cycle, ->ack 2 cycles, one beat per 2 cycles; bursts capped at MAX_BURST.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DEV-1:0]    devices_mem_en,
  input  logic [NUM_DEV-1:0]    devices_burst_en,
  input  logic [NUM_DEV-1:0]    devices_mem_we,
  input  logic [ADDR_WIDTH-1:0] device_1_mem_addr,
  input  logic [ADDR_WIDTH-1:0] device_2_mem_addr,
  input  logic [ADDR_WIDTH-1:0] device_3_mem_addr,
  input  logic [DATA_WIDTH-1:0] device_1_mem_di,
  input  logic [DATA_WIDTH-1:0] device_2_mem_di,
  input  logic [DATA_WIDTH-1:0] device_3_mem_di,
  output logic [NUM_DEV-1:0]    devices_grant,
  output logic [NUM_DEV-1:0]    devices_do_ack,
  output logic [DATA_WIDTH-1:0] mem_do,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_e                state_q;
  logic [NUM_DEV-1:0]    grant_q, ack_q;
  logic [1:0]            last_owner_q;
  logic                  we_q, ram_en_q, ram_we_q;
  logic [ADDR_WIDTH-1:0] base_q, ram_addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;

  logic [NUM_DEV-1:0]    pick;
  logic                  pick_vld, pick_we, owner_we, burst_go;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] owner_di;

  rr_select3 u_rr_select3 (
    .req_i        (devices_mem_en),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .valid_o      (pick_vld)
  );

  always_comb begin
    pick_addr = '0;
    if (pick[DEV1])      pick_addr = device_1_mem_addr;
    else if (pick[DEV2]) pick_addr = device_2_mem_addr;
    else if (pick[DEV3]) pick_addr = device_3_mem_addr;
  end

  always_comb begin
    owner_di = '0;
    if (grant_q[DEV1])      owner_di = device_1_mem_di;
    else if (grant_q[DEV2]) owner_di = device_2_mem_di;
    else if (grant_q[DEV3]) owner_di = device_3_mem_di;
  end

  assign pick_we  = |(devices_mem_we & pick);
  assign owner_we = |(devices_mem_we & grant_q);
  assign burst_go = (|(devices_mem_en & devices_burst_en & grant_q)) &&
                    (int'(beat_q) < MAX_BURST - 1);
  assign beat_d   = beat_q + BEAT_W'(1);
  assign addr_d   = base_q + ADDR_WIDTH'(beat_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      last_owner_q <= 2'(DEV3);
      we_q         <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      base_q       <= '0;
      ram_addr_q   <= '0;
      beat_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q    <= pick;
            base_q     <= pick_addr;
            we_q       <= pick_we;
            beat_q     <= '0;
            ram_en_q   <= 1'b1;
            ram_we_q   <= pick_we;
            ram_addr_q <= pick_addr;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          ack_q    <= grant_q;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          ack_q <= '0;
          // Continue only while the owner still asks for a burst and the cap is not hit.
          if (burst_go) begin
            beat_q     <= beat_d;
            we_q       <= owner_we;
            ram_en_q   <= 1'b1;
            ram_we_q   <= owner_we;
            ram_addr_q <= addr_d;
            state_q    <= ST_ACCESS;
          end else begin
            last_owner_q <= onehot_to_idx(grant_q);
            grant_q      <= '0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          grant_q  <= '0;
          ack_q    <= '0;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign devices_grant  = grant_q;
  assign devices_do_ack = ack_q;
  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_di         = owner_di;
  assign mem_do         = ((|ack_q) && !we_q) ? ram_do : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mem_en, burst_en, mem_we;
  logic [7:0] a1, a2, a3, d1, d2, d3;
  logic [2:0] grant, ack;
  logic [7:0] mem_do, ram_addr, ram_di, ram_do;
  logic       ram_en, ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .devices_mem_en(mem_en), .devices_burst_en(burst_en), .devices_mem_we(mem_we),
    .device_1_mem_addr(a1), .device_2_mem_addr(a2), .device_3_mem_addr(a3),
    .device_1_mem_di(d1), .device_2_mem_di(d2), .device_3_mem_di(d3),
    .devices_grant(grant), .devices_do_ack(ack), .mem_do(mem_do),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  // Behavioural single-port synchronous RAM, read-first, with a preload port.
  logic [7:0] ram [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr, pl_dat;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_dat;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_di;
      ram_do <= ram[ram_addr];
    end
  end

  logic [7:0] shadow [256];
  logic [7:0] cap_addr [16];
  logic [7:0] cap_do [16];
  int cap_n_acc, cap_n_ack, cap_stray;
  bit cap_done;

  task automatic set_dev(input int d, input logic [7:0] a, input logic [7:0] v, input logic w);
    case (d)
      0: begin a1 = a; d1 = v; end
      1: begin a2 = a; d2 = v; end
      default: begin a3 = a; d3 = v; end
    endcase
    mem_we[d] = w;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    pl_en = 1'b1; pl_addr = a; pl_dat = v; shadow[a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (grant === 3'b000 && ram_en === 1'b0 && ack === 3'b000) ok = 1'b1;
    end
  endtask

  // Drives one transaction from device dev and captures addresses and read data per beat.
  task automatic run_txn(input int dev, input logic [7:0] a, input logic w, input logic [7:0] v, input int want);
    set_dev(dev, a, v, w);
    mem_en = 3'b001 << dev;
    burst_en = (want > 1) ? mem_en : 3'b000;
    cap_n_acc = 0; cap_n_ack = 0; cap_stray = 0; cap_done = 1'b0;
    for (int c = 0; c < 60 && !cap_done; c++) begin
      @(negedge clk);
      if (ram_en === 1'b1 && cap_n_acc < 16) begin cap_addr[cap_n_acc] = ram_addr; cap_n_acc++; end
      if ((ack & ~(3'b001 << dev)) !== 3'b000) cap_stray++;
      if (ack[dev] === 1'b1) begin
        if (cap_n_ack < 16) cap_do[cap_n_ack] = mem_do;
        cap_n_ack++;
        if (cap_n_ack >= want) begin mem_en = 3'b000; burst_en = 3'b000; end
      end
      if (cap_n_ack > 0 && grant === 3'b000) begin
        mem_en = 3'b000; burst_en = 3'b000; cap_done = 1'b1;
      end
    end
    mem_en = 3'b000; burst_en = 3'b000;
  endtask

  task automatic test_reset();
    mem_en = 3'b000; burst_en = 3'b000; mem_we = 3'b000;
    a1 = 8'h00; a2 = 8'h00; a3 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rst_grant: got %b want 000", grant); end
    n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL rst_ack: got %b want 000", ack); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 00", ram_addr); end
    n_checks++; if (mem_do !== 8'h00) begin n_fail++; $display("FAIL rst_mem_do: got %h want 00", mem_do); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'(i * 37 + 11));
  endtask

  task automatic test_single_read();
    poke(8'h10, 8'hA5);
    set_dev(0, 8'h10, 8'h00, 1'b0);
    mem_en = 3'b001;
    @(negedge clk);
    n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL sr_grant: got %b want 001", grant); end
    n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL sr_ram_en: got %b want 1", ram_en); end
    n_checks++; if (ram_addr !== 8'h10) begin n_fail++; $display("FAIL sr_ram_addr: got %h want 10", ram_addr); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sr_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL sr_early_ack: got %b want 000", ack); end
    mem_en = 3'b000;
    @(negedge clk);
    n_checks++; if (ack !== 3'b001) begin n_fail++; $display("FAIL sr_ack: got %b want 001", ack); end
    n_checks++; if (mem_do !== 8'hA5) begin n_fail++; $display("FAIL sr_mem_do: got %h want a5", mem_do); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL sr_ram_en_resp: got %b want 0", ram_en); end
    @(negedge clk);
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL sr_grant_clear: got %b want 000", grant); end
    n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL sr_ack_clear: got %b want 000", ack); end
  endtask

  task automatic test_write_read();
    bit ok;
    run_txn(1, 8'h20, 1'b1, 8'h3C, 1);
    shadow[8'h20] = 8'h3C;
    n_checks++; if (!cap_done || cap_n_ack != 1) begin n_fail++; $display("FAIL wr_acks: got %0d done=%0d want 1", cap_n_ack, cap_done); end
    n_checks++; if (cap_addr[0] !== 8'h20) begin n_fail++; $display("FAIL wr_addr: got %h want 20", cap_addr[0]); end
    n_checks++; if (cap_stray != 0) begin n_fail++; $display("FAIL wr_stray_ack: got %0d want 0", cap_stray); end
    wait_idle(ok);
    run_txn(1, 8'h20, 1'b0, 8'h00, 1);
    n_checks++; if (!cap_done || cap_n_ack != 1) begin n_fail++; $display("FAIL rd_acks: got %0d done=%0d want 1", cap_n_ack, cap_done); end
    n_checks++; if (cap_do[0] !== 8'h3C) begin n_fail++; $display("FAIL rd_data: got %h want 3c", cap_do[0]); end
    n_checks++; if (cap_stray != 0) begin n_fail++; $display("FAIL rd_stray_ack: got %0d want 0", cap_stray); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_idle: got busy want idle"); end
  endtask

  task automatic test_burst_wrap();
    bit ok;
    logic [7:0] ea;
    run_txn(2, 8'hFE, 1'b0, 8'h00, 5);
    n_checks++; if (!cap_done) begin n_fail++; $display("FAIL bw_done: got timeout want grant release"); end
    n_checks++; if (cap_n_ack != MAXB) begin n_fail++; $display("FAIL bw_acks: got %0d want %0d", cap_n_ack, MAXB); end
    n_checks++; if (cap_n_acc != MAXB) begin n_fail++; $display("FAIL bw_accesses: got %0d want %0d", cap_n_acc, MAXB); end
    for (int k = 0; k < MAXB; k++) begin
      ea = 8'hFE + 8'(k);
      n_checks++; if (cap_addr[k] !== ea) begin n_fail++; $display("FAIL bw_addr%0d: got %h want %h", k, cap_addr[k], ea); end
      n_checks++; if (cap_do[k] !== shadow[ea]) begin n_fail++; $display("FAIL bw_data%0d: got %h want %h", k, cap_do[k], shadow[ea]); end
    end
    wait_idle(ok);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] order [4];
    logic [2:0] prevg;
    int n;
    bit ok;
    set_dev(0, 8'h01, 8'h00, 1'b0); set_dev(1, 8'h02, 8'h00, 1'b0); set_dev(2, 8'h03, 8'h00, 1'b0);
    mem_en = 3'b111; burst_en = 3'b000;
    prevg = 3'b000; n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (grant !== 3'b000 && prevg === 3'b000) begin order[n] = grant; n++; end
      prevg = grant;
    end
    mem_en = 3'b000;
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", n); end
    for (int k = 0; k < n; k++) begin
      n_checks++; if (order[k] !== exp_rr[k]) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", k, order[k], exp_rr[k]); end
    end
    wait_idle(ok);
  endtask

  task automatic test_early_end();
    int n1;
    bit seen2, got2, ok;
    set_dev(0, 8'h40, 8'h00, 1'b0); set_dev(1, 8'h50, 8'h00, 1'b0);
    mem_en = 3'b001; burst_en = 3'b001;
    @(negedge clk);
    n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL ee_grant1: got %b want 001", grant); end
    mem_en = 3'b011;
    n1 = 0; seen2 = 1'b0;
    for (int c = 0; c < 40 && !seen2; c++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin n1++; if (n1 == 2) burst_en[0] = 1'b0; end
      if (grant === 3'b010) seen2 = 1'b1;
    end
    mem_en[0] = 1'b0;
    n_checks++; if (!seen2) begin n_fail++; $display("FAIL ee_next_grant: got none want 010"); end
    n_checks++; if (n1 != 2) begin n_fail++; $display("FAIL ee_beats: got %0d want 2", n1); end
    got2 = 1'b0;
    for (int c = 0; c < 10 && !got2; c++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) begin
        got2 = 1'b1; mem_en[1] = 1'b0;
        n_checks++; if (mem_do !== shadow[8'h50]) begin n_fail++; $display("FAIL ee_dev2_data: got %h want %h", mem_do, shadow[8'h50]); end
      end
    end
    mem_en = 3'b000;
    n_checks++; if (!got2) begin n_fail++; $display("FAIL ee_dev2_ack: got none want ack"); end
    wait_idle(ok);
  endtask

  task automatic test_async_reset();
    int nacc;
    bit ok;
    set_dev(2, 8'h80, 8'h00, 1'b0);
    mem_en = 3'b100; burst_en = 3'b100;
    nacc = 0;
    for (int c = 0; c < 20 && nacc < 2; c++) begin
      @(negedge clk);
      if (ram_en === 1'b1) nacc++;
    end
    n_checks++; if (nacc != 2) begin n_fail++; $display("FAIL ar_reach_access: got %0d want 2", nacc); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL ar_grant: got %b want 000", grant); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL ar_ram_en: got %b want 0", ram_en); end
    n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL ar_ack: got %b want 000", ack); end
    @(negedge clk);
    n_checks++; if (ack !== 3'b000) begin n_fail++; $display("FAIL ar_no_inflight_ack: got %b want 000", ack); end
    set_dev(0, 8'h11, 8'h00, 1'b0); set_dev(1, 8'h12, 8'h00, 1'b0);
    mem_en = 3'b111; burst_en = 3'b000;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL ar_first_after_reset: got %b want 001", grant); end
    mem_en = 3'b000;
    wait_idle(ok);
  endtask

  // Transaction-level model: requests queued per device, owner chosen cyclically after the last owner.
  task automatic test_random();
    bit         act [3];
    logic [7:0] rb [3];
    logic [7:0] rd [3];
    logic       rw [3];
    int         rlen [3];
    int         racks [3];
    int         cur, mlast, expd, ngr;
    logic [2:0] prev_req;
    logic [7:0] a;
    bit         ok;
    mem_en = 3'b000; burst_en = 3'b000;
    reset = 1'b0;
    #2 reset = 1'b1;
    cur = -1; mlast = 2; ngr = 0; prev_req = 3'b000;
    for (int d = 0; d < 3; d++) begin act[d] = 1'b0; racks[d] = 0; rlen[d] = 1; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      n_checks++; if (!$onehot0(grant)) begin n_fail++; $display("FAIL rnd_onehot: got %b", grant); end
      n_checks++; if ((ack & ~grant) !== 3'b000) begin n_fail++; $display("FAIL rnd_ack_subset: ack %b grant %b", ack, grant); end
      if (cur >= 0 && grant === 3'b000) begin
        expd = (rlen[cur] > MAXB) ? MAXB : rlen[cur];
        n_checks++; if (racks[cur] != expd) begin n_fail++; $display("FAIL rnd_beats: dev%0d got %0d want %0d", cur + 1, racks[cur], expd); end
        act[cur] = 1'b0; mem_en[cur] = 1'b0; burst_en[cur] = 1'b0;
        mlast = cur; cur = -1;
      end else if (cur < 0 && grant !== 3'b000) begin
        expd = -1;
        for (int i = 1; i <= 3; i++) if (expd < 0 && prev_req[(mlast + i) % 3]) expd = (mlast + i) % 3;
        n_checks++;
        if (expd < 0 || grant !== (3'b001 << expd)) begin
          n_fail++; $display("FAIL rnd_grant: got %b want dev%0d (req %b last dev%0d)", grant, expd + 1, prev_req, mlast + 1);
        end
        cur = grant[2] ? 2 : (grant[1] ? 1 : 0);
        ngr++;
      end
      if (cur >= 0 && ram_en === 1'b1) begin
        a = rb[cur] + 8'(racks[cur]);
        n_checks++; if (ram_addr !== a) begin n_fail++; $display("FAIL rnd_addr: got %h want %h", ram_addr, a); end
        n_checks++; if (ram_we !== rw[cur]) begin n_fail++; $display("FAIL rnd_we: got %b want %b", ram_we, rw[cur]); end
        if (rw[cur]) begin
          n_checks++; if (ram_di !== rd[cur]) begin n_fail++; $display("FAIL rnd_di: got %h want %h", ram_di, rd[cur]); end
        end
      end
      if (cur >= 0 && ack !== 3'b000) begin
        a = rb[cur] + 8'(racks[cur]);
        if (!rw[cur]) begin
          n_checks++; if (mem_do !== shadow[a]) begin n_fail++; $display("FAIL rnd_rdata: addr %h got %h want %h", a, mem_do, shadow[a]); end
        end else shadow[a] = rd[cur];
        racks[cur]++;
        if (racks[cur] >= rlen[cur]) begin act[cur] = 1'b0; mem_en[cur] = 1'b0; burst_en[cur] = 1'b0; end
      end
      for (int d = 0; d < 3; d++) begin
        if (!act[d] && d != cur && $urandom_range(0, 3) == 0) begin
          act[d] = 1'b1; racks[d] = 0;
          rb[d] = 8'($urandom); rd[d] = 8'($urandom);
          rw[d] = 1'($urandom_range(0, 1)); rlen[d] = $urandom_range(1, 6);
          set_dev(d, rb[d], rd[d], rw[d]);
          mem_en[d] = 1'b1; burst_en[d] = (rlen[d] > 1);
        end
      end
      prev_req = mem_en;
    end
    mem_en = 3'b000; burst_en = 3'b000;
    n_checks++; if (ngr < 20) begin n_fail++; $display("FAIL rnd_activity: got %0d grants want >= 20", ngr); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_idle: got busy want idle"); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_write_read();
    test_burst_wrap();
    test_round_robin();
    test_early_end();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
